// File: rtl/timer_pkg.sv
// Register map, TCR/TSR field positions, prescaler selects and bus sequencer
// states shared by the timer control block and its prescaler.
package timer_pkg;

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    localparam int TCR_LOAD    = 7;
    localparam int TCR_UP_DOWN = 5;
    localparam int TCR_ENABLE  = 4;
    localparam int TCR_UDIE    = 3;
    localparam int TCR_OVIE    = 2;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'd0,
        CKS_DIV4  = 2'd1,
        CKS_DIV8  = 2'd2,
        CKS_DIV16 = 2'd3
    } cks_t;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_SETUP  = 2'd1,
        BUS_ACCESS = 2'd2
    } bus_state_t;

    // Unmapped addresses fail both ways; TCNT is read-only.
    function automatic logic access_error(input logic write, input logic [7:0] addr);
        return (addr > ADDR_TCNT) || (write && (addr == ADDR_TCNT));
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 4-bit clock divider producing the counter's one-cycle count tick.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cks,
    output logic       clk_ena
);

    logic [3:0] div;
    logic [3:0] div_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= 4'd0;
            div_d1 <= 4'd0;
        end else begin
            div    <= div + 4'd1;
            div_d1 <= div;
        end
    end

    // Rising edge of the selected bit: one tick every 2^(cks+1) clocks.
    // The divider is never restarted, so a cks change may slip one tick.
    assign clk_ena = div[cks] & ~div_d1[cks];

endmodule

// File: rtl/timer_ctrl.sv
// Bus front end for the 8-bit timer: register file, access sequencer,
// one-cycle load/flag-clear pulses, prescaler and interrupt combine.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic [7:0] cnt_value,
    input  logic       overflow,
    input  logic       underflow,
    output logic [7:0] start_counter,
    output logic       load,
    output logic       up_down,
    output logic       enable,
    output logic       clk_ena,
    output logic       clr_overflow,
    output logic       clr_underflow,
    output logic       irq
);

    localparam logic [1:0] WAIT_LAST = 2'(WAIT_STATES);

    bus_state_t state;
    bus_state_t state_nxt;
    logic [1:0] wait_cnt;
    logic [1:0] wait_cnt_nxt;

    cks_t       cks;
    logic       udie;
    logic       ovie;
    logic       err;
    logic       wr_commit;
    logic [7:0] rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BUS_IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pready       = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (psel && !penable) begin
                    state_nxt = BUS_SETUP;
                end
            end
            BUS_SETUP: begin
                wait_cnt_nxt = 2'd0;
                state_nxt    = psel ? BUS_ACCESS : BUS_IDLE;
            end
            BUS_ACCESS: begin
                if (!psel) begin
                    state_nxt = BUS_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Completion needs the access phase to be qualified by penable.
                    pready = penable;
                    if (penable) begin
                        state_nxt = BUS_IDLE;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            default: begin
                state_nxt = BUS_IDLE;
            end
        endcase
    end

    assign err       = access_error(pwrite, paddr);
    assign wr_commit = pready && pwrite && !err;

    always_comb begin
        rd_data = 8'h00;
        case (paddr)
            ADDR_TDR:  rd_data = start_counter;
            ADDR_TCR: begin
                rd_data[TCR_UP_DOWN] = up_down;
                rd_data[TCR_ENABLE]  = enable;
                rd_data[TCR_UDIE]    = udie;
                rd_data[TCR_OVIE]    = ovie;
                rd_data[1:0]         = cks;
            end
            ADDR_TSR: begin
                rd_data[TSR_UDF] = underflow;
                rd_data[TSR_OVF] = overflow;
            end
            ADDR_TCNT: rd_data = cnt_value;
            default:   rd_data = 8'h00;
        endcase
    end

    assign prdata  = (pready && !pwrite && !err) ? rd_data : 8'h00;
    assign pslverr = pready && err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_counter <= 8'h00;
            up_down       <= 1'b0;
            enable        <= 1'b0;
            udie          <= 1'b0;
            ovie          <= 1'b0;
            cks           <= CKS_DIV2;
        end else if (wr_commit) begin
            if (paddr == ADDR_TDR) begin
                start_counter <= pwdata;
            end
            if (paddr == ADDR_TCR) begin
                up_down <= pwdata[TCR_UP_DOWN];
                enable  <= pwdata[TCR_ENABLE];
                udie    <= pwdata[TCR_UDIE];
                ovie    <= pwdata[TCR_OVIE];
                cks     <= cks_t'(pwdata[1:0]);
            end
        end
    end

    // Pulses land in the cycle after commit, alongside the new TCR fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load          <= 1'b0;
            clr_overflow  <= 1'b0;
            clr_underflow <= 1'b0;
        end else begin
            load          <= wr_commit && (paddr == ADDR_TCR) && pwdata[TCR_LOAD];
            clr_overflow  <= wr_commit && (paddr == ADDR_TSR) && pwdata[TSR_OVF];
            clr_underflow <= wr_commit && (paddr == ADDR_TSR) && pwdata[TSR_UDF];
        end
    end

    assign irq = (overflow && ovie) || (underflow && udie);

    timer_prescaler u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .cks     (cks),
        .clk_ena (clk_ena)
    );

endmodule
